// File: rtl/matmul_seq_ctrl.sv
// Sequential 2x2 unsigned 8-bit matrix multiplier with one shared MAC and a byte-wide result stream.
// Build option: define MATMUL_SAT_EN to clamp 17-bit sums to 0xFFFF instead of wrapping to 16 bits.
module matmul_seq_ctrl #(
  parameter int OUT_MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  elem_cnt_q, elem_cnt_d;
  logic [2:0]  step_q, step_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [16:0] acc_q, acc_d;
  logic [7:0]  a_q [4];
  logic [7:0]  a_d [4];
  logic [7:0]  b_q [4];
  logic [7:0]  b_d [4];
  logic [15:0] c_q [4];
  logic [15:0] c_d [4];
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [1:0]  mac_r;
  logic        mac_t;
  logic [7:0]  a_sel;
  logic [7:0]  b_sel;
  logic [15:0] product;
  logic [16:0] mac_sum;
  logic [15:0] c_store;
  logic [2:0]  nxt_idx;
  logic [15:0] nxt_word;
  logic        nxt_hi;
  logic [7:0]  nxt_byte;

  // MAC datapath: step k selects result r=k>>1 and term t=k&1.
  always_comb begin
    mac_r   = step_q[2:1];
    mac_t   = step_q[0];
    a_sel   = a_q[{mac_r[1], mac_t}];
    b_sel   = b_q[{mac_t, mac_r[0]}];
    product = 16'(a_sel) * 16'(b_sel);
    mac_sum = (mac_t ? acc_q : 17'd0) + 17'(product);
`ifdef MATMUL_SAT_EN
    c_store = mac_sum[16] ? 16'hFFFF : mac_sum[15:0];
`else
    c_store = mac_sum[15:0];
`endif
  end

  // The first DRAIN cycle primes byte 0; later bytes are fetched as the current one is accepted.
  always_comb begin
    nxt_idx  = out_valid_q ? (byte_cnt_q + 3'd1) : 3'd0;
    nxt_word = c_q[nxt_idx[2:1]];
    nxt_hi   = nxt_idx[0] ? (OUT_MSB_FIRST == 0) : (OUT_MSB_FIRST != 0);
    nxt_byte = nxt_hi ? nxt_word[15:8] : nxt_word[7:0];
  end

  always_comb begin
    state_d     = state_q;
    elem_cnt_d  = elem_cnt_q;
    step_d      = step_q;
    byte_cnt_d  = byte_cnt_q;
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          elem_cnt_d = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      LOAD: begin
        if (in_valid && in_ready_q) begin
          if (elem_cnt_q[2]) b_d[elem_cnt_q[1:0]] = in_data;
          else               a_d[elem_cnt_q[1:0]] = in_data;
          elem_cnt_d = elem_cnt_q + 3'd1;
          if (elem_cnt_q == 3'd7) begin
            state_d    = COMPUTE;
            in_ready_d = 1'b0;
            step_d     = '0;
          end
        end
      end
      COMPUTE: begin
        acc_d = mac_sum;
        if (mac_t) c_d[mac_r] = c_store;
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d    = DRAIN;
          byte_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = nxt_byte;
        end else if (out_ready) begin
          if (byte_cnt_q == 3'd7) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            out_data_d = nxt_byte;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_cnt_q  <= '0;
      step_q      <= '0;
      byte_cnt_q  <= '0;
      acc_q       <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_cnt_q  <= elem_cnt_d;
      step_q      <= step_d;
      byte_cnt_q  <= byte_cnt_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: matrix-product model feeding an expected-byte queue.
module tb_matmul_seq_ctrl;
  localparam int MSB_FIRST = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  matmul_seq_ctrl #(.OUT_MSB_FIRST(MSB_FIRST)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // C[i][j] = sum_t A[i][t]*B[t][j], then clamp or wrap to 16 bits.
  function automatic logic [63:0] model_c(input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] res;
    int s;
    int st;
    res = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int t = 0; t < 2; t++)
          s += int'(av[31-8*(i*2+t) -: 8]) * int'(bv[31-8*(t*2+j) -: 8]);
`ifdef MATMUL_SAT_EN
        st = (s > 65535) ? 65535 : s;
`else
        st = s % 65536;
`endif
        res[63-16*(i*2+j) -: 16] = st[15:0];
      end
    end
    return res;
  endfunction

  task automatic push_expected(input logic [63:0] c);
    logic [15:0] w;
    for (int r = 0; r < 4; r++) begin
      w = c[63-16*r -: 16];
      if (MSB_FIRST != 0) begin exp_q.push_back(w[15:8]); exp_q.push_back(w[7:0]); end
      else                begin exp_q.push_back(w[7:0]);  exp_q.push_back(w[15:8]); end
    end
  endtask

  // Every cycle with out_valid the presented byte must equal the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) check("out_valid_unexpected", 64'(out_valid), 64'd0);
      else begin
        check("out_data", 64'(out_data), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic load(input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] both;
    both = {av, bv};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("in_ready_in_load", 64'(in_ready), 64'd1);
    check("busy_in_load", 64'(busy), 64'd1);
    for (int e = 0; e < 8; e++) begin
      in_valid = 1'b1;
      in_data  = both[63-8*e -: 8];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
    check("in_ready_after_load", 64'(in_ready), 64'd0);
  endtask

  task automatic measure_latency();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_out_valid_edges", 64'(n), 64'd9);
  endtask

  // mode 0: free-flowing, 1: stall 3 cycles after byte 3, 2: start/in_valid pulse mid-drain
  task automatic drain(input int mode);
    int g;
    out_ready = 1'b1;
    g = 0;
    if (mode == 1) begin
      while (exp_q.size() > 5 && g < 50) begin @(posedge clk); #1; g++; end
      out_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("stall_no_consume", 64'(exp_q.size()), 64'd5);
      out_ready = 1'b1;
    end else if (mode == 2) begin
      while (exp_q.size() > 6 && g < 50) begin @(posedge clk); #1; g++; end
      start = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0; in_data = '0;
      check("busy_after_pulse", 64'(busy), 64'd1);
      check("in_ready_after_pulse", 64'(in_ready), 64'd0);
    end
    while (exp_q.size() != 0 && g < 100) begin @(posedge clk); #1; g++; end
    check("drain_completed_in_time", 64'(exp_q.size()), 64'd0);
    check("done_pulse", 64'(done), 64'd1);
    check("busy_after_drain", 64'(busy), 64'd0);
    check("out_valid_after_drain", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    check("model_identity", model_c(32'h01000001, 32'h01020304), 64'h0001_0002_0003_0004);
    check("model_1234x5678", model_c(32'h01020304, 32'h05060708), 64'h0013_0016_002B_0032);
`ifdef MATMUL_SAT_EN
    check("model_all_ff", model_c(32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFF_FFFF_FFFF_FFFF);
`else
    check("model_all_ff", model_c(32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFC02_FC02_FC02_FC02);
`endif

    push_expected(model_c(32'h01000001, 32'h01020304));
    load(32'h01000001, 32'h01020304);
    measure_latency();
    drain(0);

    push_expected(model_c(32'h01020304, 32'h05060708));
    load(32'h01020304, 32'h05060708);
    measure_latency();
    drain(1);

    push_expected(model_c(32'hFFFFFFFF, 32'hFFFFFFFF));
    load(32'hFFFFFFFF, 32'hFFFFFFFF);
    measure_latency();
    drain(2);

    in_valid = 1'b1; in_data = 8'h77;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0;
    check("idle_in_ready", 64'(in_ready), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    load(32'h09090909, 32'h09090909);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_data", 64'(out_data), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    push_expected(model_c(32'h01020304, 32'h05060708));
    load(32'h01020304, 32'h05060708);
    measure_latency();
    drain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
